// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: default
// geometry, queue pointer width helper and read FSM state encoding.
package regfile_access_ctrl_pkg;

  localparam int unsigned N_DEFAULT        = 5;
  localparam int unsigned M_DEFAULT        = 32;
  localparam int unsigned WQ_DEPTH_DEFAULT = 4;

  // Pointer width for a power-of-two queue; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/regfile_access_ctrl_wq_fifo.sv
// Writeback queue: circular FIFO of {rd, data} entries with occupancy count
// and two address lookups that report the youngest valid entry matching each.
module regfile_access_ctrl_wq_fifo
  import regfile_access_ctrl_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned M     = M_DEFAULT,
  parameter int unsigned DEPTH = WQ_DEPTH_DEFAULT,
  parameter int unsigned PW    = ptr_width(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [N-1:0]  push_rd,
  input  logic [M-1:0]  push_data,
  input  logic          pop,
  output logic [N-1:0]  head_rd,
  output logic [M-1:0]  head_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic [N-1:0]  look_rs1,
  input  logic [N-1:0]  look_rs2,
  output logic          hit_rs1,
  output logic          hit_rs2,
  output logic [M-1:0]  hit_data_rs1,
  output logic [M-1:0]  hit_data_rs2
);

  logic [N-1:0]  rd_mem_q   [DEPTH];
  logic [M-1:0]  data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  logic [PW-1:0] idx;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;

  // Next pointers and count; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Youngest-match lookup: scan oldest to youngest so later hits overwrite earlier ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit_rs1      = 1'b0;
    hit_rs2      = 1'b0;
    hit_data_rs1 = '0;
    hit_data_rs2 = '0;
    idx          = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (rd_mem_q[idx] == look_rs1) begin
          hit_rs1      = 1'b1;
          hit_data_rs1 = data_mem_q[idx];
        end
        if (rd_mem_q[idx] == look_rs2) begin
          hit_rs2      = 1'b1;
          hit_data_rs2 = data_mem_q[idx];
        end
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only observed while count marks it valid.
    if (push_ok) begin
      rd_mem_q[wr_ptr_q]   <= push_rd;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: accepts operand reads and writebacks over
// valid/ready, queues writebacks and drains one per cycle into the register
// file, returns both operands one cycle after a read is accepted.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, reads never stall
// and pending operands are forwarded from the youngest queued write; otherwise
// reads stall until matching queued writes have drained.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned M        = M_DEFAULT,
  parameter int unsigned WQ_DEPTH = WQ_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [N-1:0]                rd_req_rs1,
  input  logic [N-1:0]                rd_req_rs2,
  output logic                        rd_rsp_valid,
  output logic [M-1:0]                rd_rsp_rs1,
  output logic [M-1:0]                rd_rsp_rs2,
  input  logic                        wr_req_valid,
  output logic                        wr_req_ready,
  input  logic [N-1:0]                wr_req_rd,
  input  logic [M-1:0]                wr_req_data,
  output logic [N-1:0]                rf_addr_rs1,
  output logic [N-1:0]                rf_addr_rs2,
  output logic [N-1:0]                rf_addr_rd,
  output logic                        rf_we,
  output logic [M-1:0]                rf_data_in,
  input  logic [M-1:0]                rf_rs1,
  input  logic [M-1:0]                rf_rs2,
  output logic [$clog2(WQ_DEPTH):0]   wq_count
);

  logic          wq_empty, wq_full, wq_pop;
  logic [N-1:0]  head_rd;
  logic [M-1:0]  head_data;
  logic          hit_rs1, hit_rs2;
  logic [M-1:0]  hit_data_rs1, hit_data_rs2;
  logic [M-1:0]  op_rs1, op_rs2;
  logic          rd_accept;
  rd_state_e     state_q, state_d;
  logic [M-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;

  regfile_access_ctrl_wq_fifo #(.N(N), .M(M), .DEPTH(WQ_DEPTH)) u_wq (
    .clk          (clk),
    .rst          (rst),
    .push         (wr_req_valid),
    .push_rd      (wr_req_rd),
    .push_data    (wr_req_data),
    .pop          (wq_pop),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .empty        (wq_empty),
    .full         (wq_full),
    .count        (wq_count),
    .look_rs1     (rd_req_rs1),
    .look_rs2     (rd_req_rs2),
    .hit_rs1      (hit_rs1),
    .hit_rs2      (hit_rs2),
    .hit_data_rs1 (hit_data_rs1),
    .hit_data_rs2 (hit_data_rs2)
  );

  // Writes drain every non-empty cycle; suppressed while reset discards the queue.
  assign wq_pop       = ~wq_empty & ~rst;
  assign wr_req_ready = ~wq_full;
  assign rf_we        = wq_pop;
  assign rf_addr_rd   = wq_pop ? head_rd : '0;
  assign rf_data_in   = wq_pop ? head_data : '0;
  assign rf_addr_rs1  = rd_req_rs1;
  assign rf_addr_rs2  = rd_req_rs2;

  // Operand select: a pending address takes the youngest queued data (only reachable when bypassing).
  assign op_rs1 = hit_rs1 ? hit_data_rs1 : rf_rs1;
  assign op_rs2 = hit_rs2 ? hit_data_rs2 : rf_rs2;

`ifdef REGFILE_BYPASS_EN
  assign rd_req_ready = 1'b1;
`else
  assign rd_req_ready = ~(hit_rs1 | hit_rs2);
`endif

  assign rd_accept    = rd_req_valid & rd_req_ready;
  assign rd_rsp_valid = (state_q == RD_RESP);
  assign rd_rsp_rs1   = rs1_q;
  assign rd_rsp_rs2   = rs2_q;

  // Read FSM next state and operand capture; data held until the next accept.
  always_comb begin
    state_d = RD_IDLE;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (rd_accept) begin
      state_d = RD_RESP;
      rs1_d   = op_rs1;
      rs2_d   = op_rs2;
    end
  end

  // Read FSM state and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

endmodule
